data_ram_resp: RTL and testbench

- Responder for the CPU data-RAM bus (address, write data, write enable, 4-bit byte select, chip enable). Holds an internal word-addressed storage array.
- Serves each access with a programmable wait-state latency. While an access is in progress it raises a stall request, which is wired into the pipeline stall controller alongside the ID/EX stall requests.
- Sits outside the core at top level, opposite the MEM stage.

---
 rtl/data_ram_resp_pkg.sv | 25 ++
 rtl/data_ram_resp_if.sv | 31 +++
 rtl/data_ram_resp_array.sv | 36 +++
 rtl/data_ram_resp.sv | 133 +++++++++++++
 tb/tb_data_ram_resp.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_ram_resp_pkg.sv
// data_ram_resp_pkg
// Shared definitions for the data-RAM responder slice:
//   - REG_BUS / reg_bus_t : CPU data-bus width and word type
//   - LANES / LANE_W      : byte-lane count and width
//   - lane_lsb()          : lowest bit of a byte lane (lane 3 -> 31:24 ... lane 0 -> 7:0)
//   - resp_state_t        : responder FSM state encoding
package data_ram_resp_pkg;

   localparam int REG_BUS = 32;
   typedef logic [REG_BUS-1:0] reg_bus_t;

   localparam int LANES  = 4;
   localparam int LANE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } resp_state_t;

   function automatic int lane_lsb(input int lane);
      return lane * LANE_W;
   endfunction

endpackage

// File: rtl/data_ram_resp_if.sv
// data_ram_resp_if
// CPU data-RAM bus between the MEM stage (master) and the responder (slave).
//   ce_i       : access request (chip enable)
//   addr_i     : byte address
//   data_i     : write data
//   we_i       : 1 = write, 0 = read
//   sel_i      : byte-lane enables, sel_i[3] -> bits 31:24
//   data_o     : read data back to the CPU
//   stallreq_o : stall request while an access is incomplete
interface data_ram_resp_if;
   import data_ram_resp_pkg::*;

   logic             ce_i;
   logic [31:0]      addr_i;
   reg_bus_t         data_i;
   logic             we_i;
   logic [LANES-1:0] sel_i;
   reg_bus_t         data_o;
   logic             stallreq_o;

   modport master (
      output ce_i, addr_i, data_i, we_i, sel_i,
      input  data_o, stallreq_o
   );

   modport slave (
      input  ce_i, addr_i, data_i, we_i, sel_i,
      output data_o, stallreq_o
   );

endinterface

// File: rtl/data_ram_resp_array.sv
// data_ram_array
// DEPTH-word x 32-bit storage with a per-byte write enable and an
// asynchronous read port. Contents are never reset.
//   clk      : write clock
//   we_lanes : per-lane write enables (bit n writes lane n)
//   addr     : word index for both read and write
//   wdata    : write data
//   rdata    : combinational read of storage[addr]
module data_ram_array
   import data_ram_resp_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic [LANES-1:0]      we_lanes,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  reg_bus_t              wdata,
   output reg_bus_t              rdata
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   reg_bus_t mem [DEPTH];

   // Only the enabled byte lanes are updated; the others keep their contents.
   always_ff @(posedge clk) begin
      for (int l = 0; l < LANES; l++) begin
         if (we_lanes[l]) begin
            mem[addr][lane_lsb(l) +: LANE_W] <= wdata[lane_lsb(l) +: LANE_W];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/data_ram_resp.sv
// data_ram_resp
// Data-RAM responder sitting opposite the MEM stage. Each access raises
// stallreq_o for WAIT_CYCLES cycles (including the request cycle), then
// presents read data / commits the write in a final DONE cycle.
// WAIT_CYCLES = 0 bypasses the FSM: combinational read, write at the same edge.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : data_ram_resp_if slave modport (CPU data-RAM bus)
module data_ram_resp
   import data_ram_resp_pkg::*;
#(
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic           clk,
   input  logic           rst,
   data_ram_resp_if.slave bus
);

   logic [DEPTH_LOG2-1:0] word_idx;
   logic [LANES-1:0]      we_lanes;
   reg_bus_t              mem_rdata;

   // Upper address bits alias onto the same words; byte-offset bits are ignored.
   assign word_idx = bus.addr_i[DEPTH_LOG2+1:2];

   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.addr_i[31:DEPTH_LOG2+2], bus.addr_i[1:0]};

   data_ram_array #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_array (
      .clk      (clk),
      .we_lanes (we_lanes),
      .addr     (word_idx),
      .wdata    (bus.data_i),
      .rdata    (mem_rdata)
   );

   generate
      if (WAIT_CYCLES == 0) begin : g_zero_wait

         logic unused_rst;
         assign unused_rst = rst;

         assign we_lanes       = (bus.ce_i && bus.we_i) ? bus.sel_i : '0;
         assign bus.data_o     = (bus.ce_i && !bus.we_i) ? mem_rdata : '0;
         assign bus.stallreq_o = 1'b0;

      end else begin : g_fsm

         // The counter holds the BUSY cycles still to go after the request cycle.
         localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

         resp_state_t      state;
         resp_state_t      next_state;
         logic [CNT_W-1:0] count;
         reg_bus_t         rd_reg;

         // State register.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               state <= IDLE;
            end else begin
               state <= next_state;
            end
         end

         // Wait counter and read-data capture; the read is taken on DONE entry
         // so the address seen at that edge is the one returned.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               count  <= '0;
               rd_reg <= '0;
            end else begin
               if (state == IDLE && bus.ce_i) begin
                  count <= CNT_W'(WAIT_CYCLES - 1);
               end else if (state == BUSY && count != '0) begin
                  count <= count - 1'b1;
               end
               if (next_state == DONE) begin
                  rd_reg <= mem_rdata;
               end
            end
         end

         // Next-state logic; dropping ce_i mid-access (flush) aborts to IDLE.
         always_comb begin
            next_state = state;
            case (state)
               IDLE: begin
                  if (bus.ce_i) begin
                     next_state = (WAIT_CYCLES == 1) ? DONE : BUSY;
                  end
               end
               BUSY: begin
                  if (!bus.ce_i) begin
                     next_state = IDLE;
                  end else if (count == CNT_W'(1)) begin
                     next_state = DONE;
                  end
               end
               DONE:    next_state = IDLE;
               default: next_state = IDLE;
            endcase
         end

         // Outputs are forced quiet while reset is held so a mid-access reset
         // drops the stall immediately even with ce_i still high.
         always_comb begin
            bus.stallreq_o = 1'b0;
            bus.data_o     = '0;
            we_lanes       = '0;
            if (rst) begin
               case (state)
                  IDLE: bus.stallreq_o = bus.ce_i;
                  BUSY: bus.stallreq_o = bus.ce_i;
                  DONE: begin
                     if (!bus.we_i) begin
                        bus.data_o = rd_reg;
                     end else if (bus.ce_i) begin
                        we_lanes = bus.sel_i;
                     end
                  end
                  default: bus.stallreq_o = 1'b0;
               endcase
            end
         end

      end
   endgenerate

endmodule

// File: tb/tb_data_ram_resp.sv
// tb_data_ram_resp
// Scoreboard bench for data_ram_resp. Two instances: dut (DEPTH_LOG2=10,
// WAIT_CYCLES=2) and dut0 (DEPTH_LOG2=4, WAIT_CYCLES=0). Stimulus pushes the
// expected response into a queue; monitors pop and compare when a response
// is presented on the bus.
module tb_data_ram_resp;

   localparam int WAIT = 2;

   typedef struct {
      logic [31:0] data;
      string       name;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   int vectors     = 0;
   int miscompares = 0;

   exp_t q[$];
   exp_t q0[$];
   exp_t mon_e;
   exp_t mon_e0;

   logic [31:0] ref_mem  [1024];
   logic [31:0] ref_mem0 [16];

   always #5 clk = ~clk;

   data_ram_resp_if bus ();
   data_ram_resp_if bus0 ();

   data_ram_resp #(
      .DEPTH_LOG2  (10),
      .WAIT_CYCLES (WAIT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   data_ram_resp #(
      .DEPTH_LOG2  (4),
      .WAIT_CYCLES (0)
   ) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   // Reference model helpers: word index from byte address, and byte-lane merge.
   function automatic int unsigned widx(input logic [31:0] a, input int dl2);
      return (a >> 2) % (1 << dl2);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] sel);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor for the wait-state instance: ce high with stall low is the DONE cycle.
   always @(negedge clk) begin
      if (rst && bus.ce_i && !bus.stallreq_o) begin
         if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected response: data_o 0x%08h, none expected", bus.data_o);
         end else begin
            mon_e = q.pop_front();
            check(mon_e.name, bus.data_o, mon_e.data);
         end
      end
   end

   // Monitor for the zero-wait instance: every ce cycle is a complete access.
   always @(negedge clk) begin
      if (bus0.ce_i) begin
         check("zw stall", {31'b0, bus0.stallreq_o}, 32'h0);
         if (q0.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL zw unexpected response: data_o 0x%08h", bus0.data_o);
         end else begin
            mon_e0 = q0.pop_front();
            check(mon_e0.name, bus0.data_o, mon_e0.data);
         end
      end
   end

   // One complete access on the wait-state instance, issued right after an edge.
   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] sel, input string tag);
      exp_t e;
      int   stalls;
      bit   done;
      @(posedge clk);
      #1;
      bus.ce_i   = 1'b1;
      bus.we_i   = we;
      bus.addr_i = addr;
      bus.data_i = data;
      bus.sel_i  = sel;
      e.name = tag;
      if (we) begin
         e.data = 32'h0;
         ref_mem[widx(addr, 10)] = merge(ref_mem[widx(addr, 10)], data, sel);
      end else begin
         e.data = ref_mem[widx(addr, 10)];
      end
      q.push_back(e);
      stalls = 0;
      done   = 1'b0;
      for (int c = 0; c < 10 && !done; c++) begin
         @(negedge clk);
         if (bus.stallreq_o) begin
            stalls++;
            @(posedge clk);
            #1;
         end else begin
            done = 1'b1;
         end
      end
      if (!done) void'(q.pop_back());
      check({tag, " stalls"}, 32'(stalls), 32'(WAIT));
   endtask

   task automatic idleCycle();
      @(posedge clk);
      #1;
      bus.ce_i = 1'b0;
      bus.we_i = 1'b0;
      bus.sel_i = 4'h0;
      @(negedge clk);
      check("idle stall", {31'b0, bus.stallreq_o}, 32'h0);
   endtask

   // Write whose ce_i is dropped in the BUSY cycle; nothing may be committed.
   task automatic abortWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
      @(posedge clk);
      #1;
      bus.ce_i   = 1'b1;
      bus.we_i   = 1'b1;
      bus.addr_i = addr;
      bus.data_i = data;
      bus.sel_i  = sel;
      @(negedge clk);
      check("abort req stall", {31'b0, bus.stallreq_o}, 32'h1);
      @(posedge clk);
      #1;
      bus.ce_i = 1'b0;
      #1;
      check("abort stall drop", {31'b0, bus.stallreq_o}, 32'h0);
      idleCycle();
   endtask

   task automatic applyZero(input logic we, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] sel, input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      bus0.ce_i   = 1'b1;
      bus0.we_i   = we;
      bus0.addr_i = addr;
      bus0.data_i = data;
      bus0.sel_i  = sel;
      e.name = tag;
      if (we) begin
         e.data = 32'h0;
         ref_mem0[widx(addr, 4)] = merge(ref_mem0[widx(addr, 4)], data, sel);
      end else begin
         e.data = ref_mem0[widx(addr, 4)];
      end
      q0.push_back(e);
   endtask

   task automatic checkOutput();
      check("dut queue empty", 32'(q.size()), 32'h0);
      check("zw queue empty", 32'(q0.size()), 32'h0);
   endtask

   initial begin
      int          r;
      int unsigned idx;
      logic [31:0] a;

      bus.ce_i = 1'b0;   bus.we_i = 1'b0;   bus.addr_i = '0;  bus.data_i = '0;  bus.sel_i = '0;
      bus0.ce_i = 1'b0;  bus0.we_i = 1'b0;  bus0.addr_i = '0; bus0.data_i = '0; bus0.sel_i = '0;

      // Reset state, including with a request pending while reset is held.
      #12;
      check("reset stall", {31'b0, bus.stallreq_o}, 32'h0);
      check("reset data_o", bus.data_o, 32'h0);
      bus.ce_i = 1'b1;
      #1;
      check("reset stall ce", {31'b0, bus.stallreq_o}, 32'h0);
      bus.ce_i = 1'b0;
      #9;
      rst = 1'b1;
      idleCycle();

      // Basic write then read.
      applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "wr 0x10");
      idleCycle();
      applyStimulus(1'b0, 32'h10, 32'h0, 4'hF, "rd 0x10");
      idleCycle();

      // Byte lanes and empty select.
      applyStimulus(1'b1, 32'h20, 32'h11223344, 4'hF, "wr 0x20");
      applyStimulus(1'b1, 32'h20, 32'hAABBCCDD, 4'b0100, "wr lane2");
      applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, "rd lane2");
      applyStimulus(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, "wr sel0");
      applyStimulus(1'b0, 32'h20, 32'h0, 4'hF, "rd sel0");
      idleCycle();

      // Back-to-back read then write, no idle gap.
      applyStimulus(1'b1, 32'h0, 32'h0, 4'hF, "init 0x0");
      applyStimulus(1'b1, 32'h8, 32'h0, 4'hF, "init 0x8");
      idleCycle();
      applyStimulus(1'b0, 32'h0, 32'h0, 4'hF, "b2b rd 0x0");
      applyStimulus(1'b1, 32'h4, 32'h12345678, 4'hF, "b2b wr 0x4");
      applyStimulus(1'b0, 32'h4, 32'h0, 4'hF, "b2b rd 0x4");
      idleCycle();

      // Abort by flush.
      abortWrite(32'h8, 32'h55555555, 4'hF);
      applyStimulus(1'b0, 32'h8, 32'h0, 4'hF, "rd after abort");
      idleCycle();

      // Reset during the BUSY cycle of a write.
      @(posedge clk);
      #1;
      bus.ce_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 32'h10; bus.data_i = 32'h77; bus.sel_i = 4'hF;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("midreset stall", {31'b0, bus.stallreq_o}, 32'h0);
      check("midreset data_o", bus.data_o, 32'h0);
      bus.ce_i = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      idleCycle();
      applyStimulus(1'b0, 32'h10, 32'h0, 4'hF, "rd after reset");
      idleCycle();

      // Randomised traffic over 16 prefilled words, random upper (aliasing) bits.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 32'(i << 2), $urandom, 4'hF, "prefill");
      end
      for (int i = 0; i < 60; i++) begin
         idx = $urandom_range(0, 15);
         a = ($urandom & 32'hFFFFF000) | 32'(idx << 2) | ($urandom & 32'h3);
         r = $urandom_range(0, 9);
         if (r == 0) abortWrite(a, $urandom, 4'($urandom));
         else if (r < 5) applyStimulus(1'b1, a, $urandom, 4'($urandom), "rnd wr");
         else applyStimulus(1'b0, a, 32'h0, 4'($urandom), "rnd rd");
         if ($urandom_range(0, 1) == 1) idleCycle();
      end
      idleCycle();

      // Zero-wait instance: aliasing directed case, then random traffic.
      applyZero(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, "zw wr 0x0");
      applyZero(1'b0, 32'h40, 32'h0, 4'hF, "zw rd 0x40");
      for (int i = 1; i < 16; i++) begin
         applyZero(1'b1, 32'(i << 2), $urandom, 4'hF, "zw prefill");
      end
      for (int i = 0; i < 40; i++) begin
         a = ($urandom & 32'hFFFFFFC0) | 32'($urandom_range(0, 15) << 2);
         if ($urandom_range(0, 1) == 1) applyZero(1'b1, a, $urandom, 4'($urandom), "zw rnd wr");
         else applyZero(1'b0, a, 32'h0, 4'hF, "zw rnd rd");
      end
      @(posedge clk);
      #1;
      bus0.ce_i = 1'b0;
      @(posedge clk);
      #1;

      checkOutput();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
